// File: rtl/ascon_permutation.sv
// Iterative Ascon permutation p^n: constant addition, 5-bit S-box layer and
// linear diffusion, UNROLL rounds per clock, under a start/busy/done handshake.
module ascon_permutation #(
   parameter int UNROLL = 1
) (
   input  logic         clock_i,
   input  logic         reset_i,
   input  logic         start_i,
   input  logic [3:0]   round_start_i,
   input  logic [319:0] state_i,
   output logic         busy_o,
   output logic         done_o,
   output logic [319:0] state_o
);

   if (UNROLL < 1 || UNROLL > 3) begin : g_bad_unroll
      $error("ascon_permutation: UNROLL must be 1, 2 or 3");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

   fsm_t           fsm_reg, fsm_next;
   logic [3:0]     round_reg;
   logic [319:0]   work_reg;
   logic [319:0]   out_reg;
   logic [319:0]   chain;
   logic [4:0]     round_sum;
   logic           last_step;
   logic           zero_rounds;

   function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   // One full round on the bit-sliced state; r is the absolute round index.
   function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] r);
      logic [63:0] x0, x1, x2, x3, x4;
      logic [63:0] t0, t1, t2, t3, t4;
      x0 = s[319:256];
      x1 = s[255:192];
      x2 = s[191:128];
      x3 = s[127:64];
      x4 = s[63:0];
      // round constant 0xF0 - 0x0F*r has high nibble 15-r and low nibble r
      x2 = x2 ^ {56'd0, ~r, r};
      // S-box applied to all 64 columns at once
      x0 = x0 ^ x4;
      x4 = x4 ^ x3;
      x2 = x2 ^ x1;
      t0 = ~x0 & x1;
      t1 = ~x1 & x2;
      t2 = ~x2 & x3;
      t3 = ~x3 & x4;
      t4 = ~x4 & x0;
      x0 = x0 ^ t1;
      x1 = x1 ^ t2;
      x2 = x2 ^ t3;
      x3 = x3 ^ t4;
      x4 = x4 ^ t0;
      x1 = x1 ^ x0;
      x0 = x0 ^ x4;
      x3 = x3 ^ x2;
      x2 = ~x2;
      // linear diffusion
      x0 = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
      x1 = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
      x2 = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
      x3 = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
      x4 = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
      return {x0, x1, x2, x3, x4};
   endfunction

   assign round_sum   = {1'b0, round_reg} + 5'(UNROLL);
   assign last_step   = (round_sum >= 5'd12);
   assign zero_rounds = (round_start_i >= 4'd12);

   // Unrolled round chain; stages past round 11 pass the state through.
   always_comb begin
      chain = work_reg;
      for (int i = 0; i < UNROLL; i++) begin
         if (({1'b0, round_reg} + 5'(i)) < 5'd12) begin
            chain = ascon_round(chain, round_reg + 4'(i));
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         fsm_reg <= IDLE;
      end else begin
         fsm_reg <= fsm_next;
      end
   end

   // Next-state logic: a zero-round request skips RUN entirely.
   always_comb begin
      fsm_next = fsm_reg;
      case (fsm_reg)
         IDLE:    if (start_i) fsm_next = zero_rounds ? DONE : RUN;
         RUN:     if (last_step) fsm_next = DONE;
         DONE:    fsm_next = IDLE;
         default: fsm_next = IDLE;
      endcase
   end

   // Datapath: latch request, iterate rounds, publish result on completion.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         round_reg <= 4'd0;
         work_reg  <= '0;
         out_reg   <= '0;
      end else begin
         case (fsm_reg)
            IDLE: begin
               if (start_i) begin
                  work_reg  <= state_i;
                  round_reg <= round_start_i;
                  if (zero_rounds) out_reg <= state_i;
               end
            end
            RUN: begin
               work_reg  <= chain;
               round_reg <= last_step ? 4'd12 : round_sum[3:0];
               if (last_step) out_reg <= chain;
            end
            default: ;
         endcase
      end
   end

   assign busy_o  = (fsm_reg == RUN);
   assign done_o  = (fsm_reg == DONE);
   assign state_o = out_reg;

endmodule
